rename_table: RTL and testbench



---
 rtl/rename_table.sv | 165 ++++++++++++++++
 tb/tb_rename_table.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_table.sv
// Speculative register alias table with physical free list for the rename stage.
// Architectural registers 2..11 are renamed; commit keeps a committed copy used to recover on flush.
module rename_table #(
  parameter int PR_ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ren_valid,
  output logic                      ren_ready,
  input  logic [1:0]                ren_dst_en,
  input  logic [7:0]                ren_dst_arch,
  output logic [2*PR_ADDR_W-1:0]    ren_dst_phys,
  output logic [2*PR_ADDR_W-1:0]    ren_old_phys,
  output logic [9:0]                rat_done,
  output logic [10*PR_ADDR_W-1:0]   rat_aliases,
  input  logic                      wb_valid,
  input  logic [PR_ADDR_W-1:0]      wb_phys,
  input  logic                      cm_valid,
  input  logic [3:0]                cm_arch,
  input  logic [PR_ADDR_W-1:0]      cm_phys,
  input  logic                      flush,
  output logic [5:0]                free_count
);

  localparam int NUM_PHYS = 1 << PR_ADDR_W;
  localparam int NUM_ARCH = 10;
  localparam logic [NUM_PHYS-1:0] F_RESET = {{(NUM_PHYS-12){1'b1}}, 12'h000};

  typedef logic [PR_ADDR_W-1:0] phys_t;

  phys_t [NUM_ARCH-1:0] a_q, a_n, ca_q, ca_n;
  logic  [NUM_ARCH-1:0] d_q, d_n;
  logic  [NUM_PHYS-1:0] f_q, f_n, cf_q, cf_n;
  logic  [5:0]          fc_q, fc_n;

  logic [3:0]          arch0, arch1;
  logic                e0, e1;
  logic [1:0]          need;
  logic                accept;
  logic                cm_ok;
  phys_t               old_ca;
  phys_t               pick0, pick1;
  phys_t               dst0, dst1, old0, old1;
  logic [NUM_PHYS-1:0] mask1;

  function automatic logic in_range(input logic [3:0] arch);
    return (arch >= 4'd2) && (arch <= 4'd11);
  endfunction

  function automatic logic [3:0] slot(input logic [3:0] arch);
    return arch - 4'd2;
  endfunction

  function automatic phys_t lowest(input logic [NUM_PHYS-1:0] v);
    phys_t r;
    r = '0;
    for (int i = NUM_PHYS - 1; i >= 0; i--)
      if (v[i]) r = phys_t'(i);
    return r;
  endfunction

  function automatic logic [5:0] popcount(input logic [NUM_PHYS-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < NUM_PHYS; i++)
      c = c + 6'(v[i]);
    return c;
  endfunction

  assign arch0  = ren_dst_arch[3:0];
  assign arch1  = ren_dst_arch[7:4];
  assign e0     = ren_dst_en[0] && in_range(arch0);
  assign e1     = ren_dst_en[1] && in_range(arch1);
  assign need   = {1'b0, e0} + {1'b0, e1};
  assign cm_ok  = cm_valid && in_range(cm_arch);
  assign old_ca = ca_q[slot(cm_arch)];

  assign ren_ready = !flush && !rst && (fc_q >= {4'b0000, need});
  assign accept    = ren_valid && ren_ready;

  // dest1 skips dest0's pick only when dest0 is actually allocating
  always_comb begin
    mask1 = f_q;
    pick0 = lowest(f_q);
    if (e0) mask1[pick0] = 1'b0;
    pick1 = lowest(mask1);
  end

  // Same-arch pair: dest1 replaces dest0's brand-new alias, not the table entry
  always_comb begin
    dst0 = e0 ? pick0 : phys_t'(0);
    dst1 = e1 ? pick1 : phys_t'(0);
    old0 = e0 ? a_q[slot(arch0)] : phys_t'(0);
    old1 = phys_t'(0);
    if (e1) old1 = (e0 && (arch0 == arch1)) ? pick0 : a_q[slot(arch1)];
  end

  assign ren_dst_phys = {dst1, dst0};
  assign ren_old_phys = {old1, old0};

  always_comb begin
    a_n  = a_q;
    d_n  = d_q;
    f_n  = f_q;
    ca_n = ca_q;
    cf_n = cf_q;
    if (cm_ok) begin
      ca_n[slot(cm_arch)] = cm_phys;
      if (old_ca > phys_t'(1)) begin
        f_n[old_ca]  = 1'b1;
        cf_n[old_ca] = 1'b1;
      end
      cf_n[cm_phys] = 1'b0;
    end
    // Flush rebuilds speculative state from the committed copy after this cycle's commit
    if (flush) begin
      a_n = ca_n;
      f_n = cf_n;
      d_n = '1;
    end else begin
      if (wb_valid && (wb_phys > phys_t'(1))) begin
        for (int i = 0; i < NUM_ARCH; i++)
          if (a_q[i] == wb_phys) d_n[i] = 1'b1;
      end
      if (accept) begin
        if (e0) begin
          f_n[pick0]       = 1'b0;
          a_n[slot(arch0)] = pick0;
          d_n[slot(arch0)] = 1'b0;
        end
        if (e1) begin
          f_n[pick1]       = 1'b0;
          a_n[slot(arch1)] = pick1;
          d_n[slot(arch1)] = 1'b0;
        end
      end
    end
    fc_n = popcount(f_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        a_q[i]  <= phys_t'(i + 2);
        ca_q[i] <= phys_t'(i + 2);
      end
      d_q  <= '1;
      f_q  <= F_RESET;
      cf_q <= F_RESET;
      fc_q <= 6'(NUM_PHYS - 12);
    end else begin
      a_q  <= a_n;
      d_q  <= d_n;
      f_q  <= f_n;
      ca_q <= ca_n;
      cf_q <= cf_n;
      fc_q <= fc_n;
    end
  end

  assign rat_aliases = a_q;
  assign rat_done    = d_q;
  assign free_count  = fc_q;

endmodule

// File: tb/tb_rename_table.sv
// Testbench for rename_table: directed vector table, exhaustion/flush sequences,
// and randomized traffic against a behavioural model of the alias table and free list.
module tb_rename_table;

  localparam int W = 5;

  logic            clk = 1'b0;
  logic            rst, ren_valid, ren_ready;
  logic [1:0]      ren_dst_en;
  logic [7:0]      ren_dst_arch;
  logic [2*W-1:0]  ren_dst_phys, ren_old_phys;
  logic [9:0]      rat_done;
  logic [10*W-1:0] rat_aliases;
  logic            wb_valid, cm_valid, flush;
  logic [W-1:0]    wb_phys, cm_phys;
  logic [3:0]      cm_arch;
  logic [5:0]      free_count;

  rename_table #(.PR_ADDR_W(W)) dut (
    .clk(clk), .rst(rst), .ren_valid(ren_valid), .ren_ready(ren_ready),
    .ren_dst_en(ren_dst_en), .ren_dst_arch(ren_dst_arch),
    .ren_dst_phys(ren_dst_phys), .ren_old_phys(ren_old_phys),
    .rat_done(rat_done), .rat_aliases(rat_aliases),
    .wb_valid(wb_valid), .wb_phys(wb_phys),
    .cm_valid(cm_valid), .cm_arch(cm_arch), .cm_phys(cm_phys),
    .flush(flush), .free_count(free_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: plain arrays indexed by architectural / physical number
  int ma[16];
  bit md[16];
  int mca[16];
  bit mf[32];
  bit mcf[32];
  typedef struct { int arch; int np; } rob_t;
  rob_t rob[$];
  bit   cm_from_rob;

  bit   m_e0, m_e1, m_ready;
  int   m_p0, m_p1, m_o0, m_o1;

  typedef struct {
    bit r, v; bit [1:0] en; bit [7:0] arch;
    bit wv; bit [4:0] wp; bit cv; bit [3:0] ca; bit [4:0] cp; bit fl;
    bit x_ready; bit [9:0] x_dst, x_old, x_done; bit [5:0] x_fc; bit [4:0] x_a2;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin ma[i] = i; mca[i] = i; md[i] = 1'b1; end
    for (int i = 0; i < 32; i++) begin mf[i] = (i >= 12); mcf[i] = (i >= 12); end
    rob.delete();
  endtask

  function automatic int lowest(int excl);
    for (int i = 0; i < 32; i++)
      if (mf[i] && i != excl) return i;
    return 0;
  endfunction

  function automatic int modelCount();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(mf[i]);
    return c;
  endfunction

  task automatic modelComb();
    int a0, a1;
    a0 = int'(ren_dst_arch[3:0]);
    a1 = int'(ren_dst_arch[7:4]);
    m_e0 = ren_dst_en[0] && a0 >= 2 && a0 <= 11;
    m_e1 = ren_dst_en[1] && a1 >= 2 && a1 <= 11;
    m_ready = !flush && !rst && (modelCount() >= int'(m_e0) + int'(m_e1));
    m_p0 = lowest(-1);
    m_p1 = lowest(m_e0 ? m_p0 : -1);
    m_o0 = m_e0 ? ma[a0] : 0;
    m_o1 = m_e1 ? ((m_e0 && a0 == a1) ? m_p0 : ma[a1]) : 0;
  endtask

  task automatic modelTick();
    int a0, a1, old;
    a0 = int'(ren_dst_arch[3:0]);
    a1 = int'(ren_dst_arch[7:4]);
    if (cm_from_rob && rob.size() > 0) void'(rob.pop_front());
    if (rst) begin
      modelReset();
      return;
    end
    if (cm_valid && cm_arch >= 2 && cm_arch <= 11) begin
      old = mca[cm_arch];
      mca[cm_arch] = int'(cm_phys);
      if (old > 1) begin mf[old] = 1'b1; mcf[old] = 1'b1; end
      mcf[cm_phys] = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < 16; i++) begin ma[i] = mca[i]; md[i] = 1'b1; end
      for (int i = 0; i < 32; i++) mf[i] = mcf[i];
      rob.delete();
    end else begin
      if (wb_valid && wb_phys > 1)
        for (int i = 2; i <= 11; i++) if (ma[i] == int'(wb_phys)) md[i] = 1'b1;
      if (ren_valid && m_ready) begin
        if (m_e0) begin mf[m_p0] = 1'b0; ma[a0] = m_p0; md[a0] = 1'b0; rob.push_back('{a0, m_p0}); end
        if (m_e1) begin mf[m_p1] = 1'b0; ma[a1] = m_p1; md[a1] = 1'b0; rob.push_back('{a1, m_p1}); end
      end
    end
  endtask

  task automatic checkOutput(input bit after_edge);
    logic [10*W-1:0] x_alias;
    logic [9:0]      x_done;
    if (!after_edge) begin
      check("ren_ready", ren_ready, m_ready);
      if (ren_valid && m_ready) begin
        check("ren_dst_phys", ren_dst_phys, {W'(m_e1 ? m_p1 : 0), W'(m_e0 ? m_p0 : 0)});
        check("ren_old_phys", ren_old_phys, {W'(m_o1), W'(m_o0)});
      end
    end else begin
      for (int i = 0; i < 10; i++) begin
        x_alias[i*W +: W] = W'(ma[i+2]);
        x_done[i] = md[i+2];
      end
      check("rat_aliases", rat_aliases, x_alias);
      check("rat_done", rat_done, x_done);
      check("free_count", free_count, 6'(modelCount()));
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input bit [1:0] en, input bit [7:0] arch,
                               input bit wv, input bit [4:0] wp, input bit cv, input bit [3:0] ca,
                               input bit [4:0] cp, input bit fl);
    rst = r; ren_valid = v; ren_dst_en = en; ren_dst_arch = arch;
    wb_valid = wv; wb_phys = wp; cm_valid = cv; cm_arch = ca; cm_phys = cp; flush = fl;
    #1;
    modelComb();
    checkOutput(1'b0);
  endtask

  task automatic clockStep();
    @(posedge clk);
    modelTick();
    #1;
    checkOutput(1'b1);
  endtask

  initial begin
    cm_from_rob = 1'b0;
    modelReset();

    //              r v en    arch   wv wp  cv ca  cp  fl | rdy dst     old     done    fc  a2
    tbl[0] = '{1,0,2'd0,8'h00,0,5'd0, 0,4'd0,5'd0, 0, 0,10'h000,10'h000,10'h3FF,6'd20,5'd2};
    tbl[1] = '{0,1,2'd3,8'h32,0,5'd0, 0,4'd0,5'd0, 0, 1,10'h1AC,10'h062,10'h3FC,6'd18,5'd12};
    tbl[2] = '{0,1,2'd1,8'h02,1,5'd12,0,4'd0,5'd0, 0, 1,10'h00E,10'h00C,10'h3FC,6'd17,5'd14};
    tbl[3] = '{0,0,2'd0,8'h00,1,5'd14,0,4'd0,5'd0, 0, 1,10'h000,10'h000,10'h3FD,6'd17,5'd14};
    tbl[4] = '{0,1,2'd1,8'h05,0,5'd0, 1,4'd2,5'd12,1, 0,10'h000,10'h000,10'h3FF,6'd20,5'd12};
    tbl[5] = '{1,0,2'd0,8'h00,0,5'd0, 0,4'd0,5'd0, 0, 0,10'h000,10'h000,10'h3FF,6'd20,5'd2};
    tbl[6] = '{0,1,2'd3,8'h44,0,5'd0, 0,4'd0,5'd0, 0, 1,10'h1AC,10'h184,10'h3FB,6'd18,5'd2};
    tbl[7] = '{0,1,2'd3,8'hC0,0,5'd0, 0,4'd0,5'd0, 0, 1,10'h000,10'h000,10'h3FB,6'd18,5'd2};
    tbl[8] = '{0,1,2'd3,8'h15,0,5'd0, 0,4'd0,5'd0, 0, 1,10'h00E,10'h005,10'h3F3,6'd17,5'd2};
    tbl[9] = '{0,0,2'd0,8'h00,1,5'd0, 1,4'd13,5'd14,0,1,10'h000,10'h000,10'h3F3,6'd17,5'd2};

    for (int k = 0; k < 10; k++) begin
      applyStimulus(tbl[k].r, tbl[k].v, tbl[k].en, tbl[k].arch, tbl[k].wv, tbl[k].wp,
                    tbl[k].cv, tbl[k].ca, tbl[k].cp, tbl[k].fl);
      check($sformatf("vec%0d ready", k), ren_ready, tbl[k].x_ready);
      if (tbl[k].v && tbl[k].x_ready) begin
        check($sformatf("vec%0d dst", k), ren_dst_phys, tbl[k].x_dst);
        check($sformatf("vec%0d old", k), ren_old_phys, tbl[k].x_old);
      end
      clockStep();
      check($sformatf("vec%0d done", k), rat_done, tbl[k].x_done);
      check($sformatf("vec%0d free_count", k), free_count, tbl[k].x_fc);
      check($sformatf("vec%0d alias2", k), rat_aliases[W-1:0], tbl[k].x_a2);
    end

    // Exhaust the free list, then free one register through commit
    applyStimulus(1, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0);
    clockStep();
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 1, 2'd1, 8'h02, 0, 0, 0, 0, 0, 0);
      clockStep();
    end
    check("exhaust free_count", free_count, 6'd0);
    applyStimulus(0, 1, 2'd1, 8'h03, 0, 0, 0, 0, 0, 0);
    check("exhaust refuse", ren_ready, 1'b0);
    clockStep();
    applyStimulus(0, 1, 2'd3, 8'hF0, 0, 0, 0, 0, 0, 0);
    check("exhaust no-dest accept", ren_ready, 1'b1);
    clockStep();
    applyStimulus(0, 0, 2'd0, 8'h00, 0, 0, 1, 4'd2, 5'd12, 0);
    clockStep();
    check("commit frees one", free_count, 6'd1);
    applyStimulus(0, 1, 2'd3, 8'h32, 0, 0, 0, 0, 0, 0);
    check("one free two dests", ren_ready, 1'b0);
    clockStep();
    applyStimulus(0, 1, 2'd1, 8'h03, 0, 0, 0, 0, 0, 0);
    check("one free one dest", ren_ready, 1'b1);
    check("reuse phys 2", ren_dst_phys, 10'h002);
    clockStep();
    check("refilled empty", free_count, 6'd0);

    // Randomized traffic with in-order commits drawn from the model's own ROB
    applyStimulus(1, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0);
    clockStep();
    for (int k = 0; k < 500; k++) begin
      bit r, v, wv, cv, fl;
      bit [3:0] ca;
      bit [4:0] cp;
      r  = ($urandom_range(99) == 0);
      fl = ($urandom_range(24) == 0);
      v  = ($urandom_range(9) < 7);
      wv = $urandom_range(1);
      cv = (rob.size() > 0) && ($urandom_range(1) == 1);
      ca = cv ? 4'(rob[0].arch) : 4'($urandom);
      cp = cv ? 5'(rob[0].np) : 5'($urandom);
      cm_from_rob = cv;
      applyStimulus(r, v, 2'($urandom), {4'($urandom_range(13)), 4'($urandom_range(13))},
                    wv, 5'($urandom), cv, ca, cp, fl);
      clockStep();
      cm_from_rob = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
